// File: rtl/csa_accumulator_pkg.sv
// csa_accumulator_pkg
// Shared types and sizing helpers for the carry-save accumulator.
//   acc_state_e      : controller states (accumulate, resolve, present result)
//   acc_width()      : accumulator width from operand width plus guard bits
//   resolve_cycles() : number of chunked-adder cycles needed to resolve a total
//   idx_width()      : width of the chunk index counter (never below 1 bit)
package csa_accumulator_pkg;

  // Default sizing used by the interface and the top level.
  localparam int DEFAULT_N     = 32;
  localparam int DEFAULT_G     = 4;
  localparam int DEFAULT_CHUNK = 9;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } acc_state_e;

  function automatic int acc_width(input int n, input int g);
    return n + g;
  endfunction

  function automatic int resolve_cycles(input int acc_w, input int chunk);
    return acc_w / chunk;
  endfunction

  // $clog2(1) is 0, so a single-chunk configuration still gets a 1-bit index.
  function automatic int idx_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// csa_accumulator_if
// Operand stream in, resolved sum out.
//   in_valid/in_ready/in_data/in_last : operand beats, in_last marks packet end
//   out_valid/out_ready               : result handshake
//   out_sum                           : packet sum modulo 2^ACC_W
//   out_ovf                           : sticky flag, true sum did not fit ACC_W
// The master modport is the side that produces operands and consumes results;
// the slave modport is the accumulator.
interface csa_accumulator_if
  import csa_accumulator_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int G = DEFAULT_G
);

  localparam int ACC_W = acc_width(N, G);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_last,
    input  out_valid,
    output out_ready,
    input  out_sum,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_last,
    output out_valid,
    input  out_ready,
    output out_sum,
    output out_ovf
  );

endinterface

// File: rtl/csa_accumulator_csa_row.sv
// csa_row
// One row of independent full adders over three W-bit vectors.
//   a, b, c : addends
//   sum     : per-bit sum
//   carry   : per-bit carry, unshifted; carry[W-1] is the bit that falls off
//             the top once the parent shifts the vector into place
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  // Each bit is a full adder with no dependency on its neighbours, so the
  // row delay is constant regardless of width.
  always_comb begin
    sum   = a ^ b ^ c;
    carry = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator
// Sums an arbitrary-length packet of operands. The running total is kept as a
// redundant (sum, carry) pair so each beat costs one full-adder row. After the
// last beat the pair is collapsed by a CHUNK-bit ripple adder over R cycles,
// low chunk first, and the binary result is presented with a sticky overflow.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any packet in flight
//   bus  : csa_accumulator_if slave (operand stream in, result out)
// ACC_W must be a multiple of CHUNK.
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int G     = DEFAULT_G,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  csa_accumulator_if.slave bus
);

  localparam int ACC_W = acc_width(N, G);
  localparam int R     = resolve_cycles(ACC_W, CHUNK);
  localparam int IDX_W = idx_width(R);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cin_q, cin_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] operand;
  logic [ACC_W-1:0] row_sum;
  logic [ACC_W-1:0] row_carry;
  logic [CHUNK-1:0] chunk_s;
  logic [CHUNK-1:0] chunk_c;
  logic [CHUNK:0]   chunk_total;
  logic             accept;

  assign operand = {{G{1'b0}}, bus.in_data};
  assign accept  = bus.in_valid & in_ready_q;

  csa_row #(.W(ACC_W)) u_row (
    .a     (s_q),
    .b     (c_q),
    .c     (operand),
    .sum   (row_sum),
    .carry (row_carry)
  );

  // in_ready is forced low while reset is held; the flop itself comes out of
  // reset high so the accumulator is ready on the first cycle after release.
  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = result_q;
  assign bus.out_ovf   = ovf_q;

  // Next-state logic for the whole controller. The chunk being resolved is
  // picked with a constant-index loop so every part-select is static.
  // A carry leaving the top of a CSA row, or the top chunk of the resolver,
  // means the true sum reached 2^ACC_W, so both feed the sticky flag.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    idx_d       = idx_q;
    cin_d       = cin_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    chunk_s     = '0;
    chunk_c     = '0;

    for (int k = 0; k < R; k++) begin
      if (idx_q == IDX_W'(k)) begin
        chunk_s = s_q[k*CHUNK +: CHUNK];
        chunk_c = c_q[k*CHUNK +: CHUNK];
      end
    end
    chunk_total = {1'b0, chunk_s} + {1'b0, chunk_c} + {{CHUNK{1'b0}}, cin_q};

    case (state_q)
      ST_ACC: begin
        if (accept) begin
          s_d   = row_sum;
          c_d   = {row_carry[ACC_W-2:0], 1'b0};
          ovf_d = ovf_q | row_carry[ACC_W-1];
          if (bus.in_last) begin
            state_d    = ST_RESOLVE;
            idx_d      = '0;
            cin_d      = 1'b0;
            in_ready_d = 1'b0;
          end
        end
      end

      ST_RESOLVE: begin
        for (int k = 0; k < R; k++) begin
          if (idx_q == IDX_W'(k)) begin
            result_d[k*CHUNK +: CHUNK] = chunk_total[CHUNK-1:0];
          end
        end
        cin_d = chunk_total[CHUNK];
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(R - 1)) begin
          ovf_d       = ovf_q | chunk_total[CHUNK];
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          s_d         = '0;
          c_d         = '0;
          ovf_d       = 1'b0;
          state_d     = ST_ACC;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = ST_ACC;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register. Reset clears the redundant pair and the flag so an
  // aborted packet leaves nothing behind for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      s_q         <= '0;
      c_q         <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      idx_q       <= '0;
      cin_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      idx_q       <= idx_d;
      cin_q       <= cin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator
// Drives operand packets into csa_accumulator (N=8, G=2, CHUNK=5) and checks
// every result against a plain-integer sum kept by the bench.
module tb_csa_accumulator;

  localparam int N     = 8;
  localparam int G     = 2;
  localparam int CHUNK = 5;
  localparam int ACC_W = 10;
  localparam int MOD   = 1 << ACC_W;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } result_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  result_t expQ[$];
  result_t monExp;
  int      assertCount = 0;
  int      failCount   = 0;
  int      modelSum    = 0;
  bit      randomReady = 1'b0;
  logic    forcedReady = 1'b0;

  always #5 clk = ~clk;

  csa_accumulator_if #(.N(N), .G(G)) bus ();

  csa_accumulator #(.N(N), .G(G), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One comparison: counts it, and reports a mismatch with both values.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one beat after an optional idle gap and holds it until accepted.
  // On acceptance the reference total is updated; on the last beat the
  // expected result is queued for the monitor.
  task automatic applyStimulus(input logic [N-1:0] data, input logic last, input int gap);
    bit accepted = 1'b0;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = N'($urandom);
      bus.in_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = N'($urandom);
    bus.in_last  = 1'($urandom);
    assertCount++;
    if (!accepted) begin
      failCount++;
      $display("[TB] FAIL beat_accept: actual not accepted in 200 cycles, expected accepted (data 0x%0h)", data);
    end else begin
      modelSum += int'(data);
      if (last) begin
        result_t e;
        e.sum = ACC_W'(modelSum % MOD);
        e.ovf = (modelSum >= MOD);
        expQ.push_back(e);
        modelSum = 0;
      end
    end
  endtask

  // Waits until the monitor has consumed every queued result, then steps
  // past the edge that completes the final handshake.
  task automatic drainScoreboard();
    for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: actual %0d results outstanding, expected 0", expQ.size());
    end
  endtask

  // Result consumer: either held at a chosen level or toggled randomly.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = randomReady ? 1'($urandom_range(0, 1)) : forcedReady;
    end
  end

  // Monitor: every completed result handshake is compared with the oldest
  // expectation in the queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_result: actual sum 0x%0h, expected no result", bus.out_sum);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("out_sum", 32'(bus.out_sum), 32'(monExp.sum));
        checkOutput("out_ovf", 32'(bus.out_ovf), 32'(monExp.ovf));
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: actual time limit reached, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    rst          = 1'b1;

    // Reset values.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    end
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_sum", 32'(bus.out_sum), 32'd0);
    checkOutput("reset_out_ovf", 32'(bus.out_ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Single beat, latency of exactly R=2 cycles.
    $display("[TB] single beat");
    forcedReady = 1'b0;
    applyStimulus(8'hA5, 1'b1, 0);
    @(negedge clk);
    checkOutput("lat_valid_e0", 32'(bus.out_valid), 32'd0);
    checkOutput("lat_ready_e0", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("lat_valid_e1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_valid_e2", 32'(bus.out_valid), 32'd1);
    forcedReady = 1'b1;
    drainScoreboard();
    @(negedge clk);
    checkOutput("in_ready_after_result", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Back-to-back 0xFF, just below and just above the accumulator range.
    $display("[TB] four and five beats of 0xFF");
    for (int b = 0; b < 4; b++) applyStimulus(8'hFF, 1'(b == 3), 0);
    drainScoreboard();
    for (int b = 0; b < 5; b++) applyStimulus(8'hFF, 1'(b == 4), 0);
    drainScoreboard();

    // Gapped beats, then a held result.
    $display("[TB] gapped packet with held result");
    forcedReady = 1'b0;
    applyStimulus(8'h10, 1'b0, 0);
    applyStimulus(8'h20, 1'b0, 1);
    applyStimulus(8'h30, 1'b1, 1);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold_sum", 32'(bus.out_sum), 32'h060);
      checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    forcedReady = 1'b1;
    drainScoreboard();
    applyStimulus(8'h03, 1'b0, 0);
    applyStimulus(8'h04, 1'b1, 0);
    drainScoreboard();

    // Reset in the middle of resolving an overflowing packet.
    $display("[TB] reset during resolve");
    for (int b = 0; b < 5; b++) applyStimulus(8'hFF, 1'(b == 4), 0);
    rst = 1'b1;
    void'(expQ.pop_back());
    @(negedge clk);
    checkOutput("abort_in_ready_rst", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_ready_after", 32'(bus.in_ready), 32'd1);
    repeat (4) begin
      checkOutput("abort_no_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    applyStimulus(8'h01, 1'b1, 0);
    drainScoreboard();

    // Random packets with random gaps and random result back-pressure.
    $display("[TB] random packets");
    randomReady = 1'b1;
    for (int p = 0; p < 30; p++) begin
      len = int'($urandom_range(1, 20));
      for (int b = 0; b < len; b++) begin
        applyStimulus(N'($urandom_range(0, 255)), 1'(b == len - 1), int'($urandom_range(0, 2)));
      end
    end
    drainScoreboard();
    randomReady = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
